// File: rtl/forward_propagation_pkg.sv
// Shared Q8.8 constants, PLAN sigmoid breakpoints and the forward-pass FSM encoding.
// Also holds the two-term multiply-accumulate used by both network layers.
package forward_propagation_pkg;

  localparam int          FRAC_BITS   = 8;
  localparam logic [15:0] ONE         = 16'h0100;
  localparam logic [15:0] SIG_BP_SAT  = 16'h0500;  // 5.0
  localparam logic [15:0] SIG_BP_HI   = 16'h0260;  // 2.375
  localparam logic [15:0] SIG_BP_MID  = ONE;       // 1.0
  localparam logic [15:0] SIG_OFS_HI  = 16'h00D8;
  localparam logic [15:0] SIG_OFS_MID = 16'h00A0;
  localparam logic [15:0] SIG_OFS_LO  = 16'h0080;
  localparam logic [15:0] Q_MAX       = 16'h7FFF;
  localparam logic [15:0] Q_MIN       = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L1,
    ST_A1,
    ST_L2,
    ST_A2,
    ST_DONE
  } fp_state_e;

  // wa*xa + wb*xb + b, each product rescaled to Q8.8, summed in 32 bits and saturated.
  function automatic logic [15:0] mac2(input logic signed [15:0] wa,
                                       input logic signed [15:0] xa,
                                       input logic signed [15:0] wb,
                                       input logic signed [15:0] xb,
                                       input logic signed [15:0] b);
    logic signed [31:0] pa;
    logic signed [31:0] pb;
    logic signed [31:0] s;
    pa = (32'(wa) * 32'(xa)) >>> FRAC_BITS;
    pb = (32'(wb) * 32'(xb)) >>> FRAC_BITS;
    s  = pa + pb + 32'(b);
    if (s > 32'sd32767)       return Q_MAX;
    else if (s < -32'sd32768) return Q_MIN;
    else                      return s[15:0];
  endfunction

endpackage

// File: rtl/forward_propagation_sigmoid_plan.sv
// Combinational piecewise-linear (PLAN) sigmoid on a signed Q8.8 operand.
// Output is Q8.8 in [0x0000, 0x0100].
module forward_propagation_sigmoid_plan
  import forward_propagation_pkg::*;
(
  input  logic [15:0] z_i,
  output logic [15:0] sig_o
);

  logic        neg;
  logic [15:0] mag;
  logic [15:0] f_pos;

  assign neg = z_i[15];

  // 0x8000 has no positive twin in 16 bits; treat it as the largest magnitude.
  always_comb begin
    mag = z_i;
    if (z_i == Q_MIN) mag = Q_MAX;
    else if (neg)     mag = ~z_i + 16'd1;
  end

  always_comb begin
    f_pos = ONE;
    if (mag >= SIG_BP_SAT)      f_pos = ONE;
    else if (mag >= SIG_BP_HI)  f_pos = (mag >> 5) + SIG_OFS_HI;
    else if (mag >= SIG_BP_MID) f_pos = (mag >> 3) + SIG_OFS_MID;
    else                        f_pos = (mag >> 2) + SIG_OFS_LO;
  end

  assign sig_o = neg ? (ONE - f_pos) : f_pos;

endmodule

// File: rtl/forward_propagation.sv
// Forward pass of a 2-2-1 MLP in Q8.8: latches operands, computes hidden and output layers,
// and re-exports the weight set it used for the back-propagation stage.
//
//  state   | meaning
//  IDLE    | wait for enable_fp, latch inputs and weights
//  L1      | hidden pre-activations z1, z2
//  A1      | hidden activations h1, h2
//  L2      | output pre-activation z3
//  A2      | output activation y
//  DONE    | fp_valid asserted; hold while enable_fp
module forward_propagation
  import forward_propagation_pkg::*;
#(
  parameter int dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_fp,
  input  logic [dataWidth-1:0] x1,
  input  logic [dataWidth-1:0] x2,
  input  logic [dataWidth-1:0] w11,
  input  logic [dataWidth-1:0] w12,
  input  logic [dataWidth-1:0] w21,
  input  logic [dataWidth-1:0] w22,
  input  logic [dataWidth-1:0] w31,
  input  logic [dataWidth-1:0] w32,
  input  logic [dataWidth-1:0] b1,
  input  logic [dataWidth-1:0] b2,
  input  logic [dataWidth-1:0] b3,
  output logic [dataWidth-1:0] h1,
  output logic [dataWidth-1:0] h2,
  output logic [dataWidth-1:0] y,
  output logic [dataWidth-1:0] w11_out,
  output logic [dataWidth-1:0] w12_out,
  output logic [dataWidth-1:0] w21_out,
  output logic [dataWidth-1:0] w22_out,
  output logic [dataWidth-1:0] w31_out,
  output logic [dataWidth-1:0] w32_out,
  output logic [dataWidth-1:0] b1_out,
  output logic [dataWidth-1:0] b2_out,
  output logic [dataWidth-1:0] b3_out,
  output logic                 fp_valid
);

  fp_state_e state_q, state_d;
  logic load_en, l1_en, a1_en, l2_en, a2_en, fp_valid_d, fp_valid_q;

  logic [15:0] x1_q, x2_q;
  logic [15:0] w11_q, w12_q, w21_q, w22_q, w31_q, w32_q, b1_q, b2_q, b3_q;
  logic [15:0] z1_q, z2_q, z3_q, h1_q, h2_q, y_q;
  logic [15:0] sig_z1, sig_z2, sig_z3;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable_fp) state_d = ST_L1;
      ST_L1:   state_d = ST_A1;
      ST_A1:   state_d = ST_L2;
      ST_L2:   state_d = ST_A2;
      ST_A2:   state_d = ST_DONE;
      ST_DONE: if (!enable_fp) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // First DONE cycle always raises fp_valid so an early release still yields a one-cycle pulse.
  always_comb begin
    load_en    = 1'b0;
    l1_en      = 1'b0;
    a1_en      = 1'b0;
    l2_en      = 1'b0;
    a2_en      = 1'b0;
    fp_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: load_en    = enable_fp;
      ST_L1:   l1_en      = 1'b1;
      ST_A1:   a1_en      = 1'b1;
      ST_L2:   l2_en      = 1'b1;
      ST_A2:   a2_en      = 1'b1;
      ST_DONE: fp_valid_d = enable_fp || !fp_valid_q;
      default: fp_valid_d = 1'b0;
    endcase
  end

  forward_propagation_sigmoid_plan u_sig_h1 (.z_i(z1_q), .sig_o(sig_z1));
  forward_propagation_sigmoid_plan u_sig_h2 (.z_i(z2_q), .sig_o(sig_z2));
  forward_propagation_sigmoid_plan u_sig_y  (.z_i(z3_q), .sig_o(sig_z3));

  always_ff @(posedge clk) begin
    if (rst) begin
      {x1_q, x2_q}                          <= '0;
      {w11_q, w12_q, w21_q, w22_q}          <= '0;
      {w31_q, w32_q, b1_q, b2_q, b3_q}      <= '0;
      {z1_q, z2_q, z3_q, h1_q, h2_q, y_q}   <= '0;
      fp_valid_q                            <= 1'b0;
    end else begin
      if (load_en) begin
        x1_q  <= x1;  x2_q  <= x2;
        w11_q <= w11; w12_q <= w12; w21_q <= w21; w22_q <= w22;
        w31_q <= w31; w32_q <= w32;
        b1_q  <= b1;  b2_q  <= b2;  b3_q  <= b3;
      end
      if (l1_en) begin
        z1_q <= mac2(w11_q, x1_q, w12_q, x2_q, b1_q);
        z2_q <= mac2(w21_q, x1_q, w22_q, x2_q, b2_q);
      end
      if (a1_en) begin
        h1_q <= sig_z1;
        h2_q <= sig_z2;
      end
      if (l2_en) z3_q <= mac2(w31_q, h1_q, w32_q, h2_q, b3_q);
      if (a2_en) y_q  <= sig_z3;
      fp_valid_q <= fp_valid_d;
    end
  end

  assign h1       = h1_q;
  assign h2       = h2_q;
  assign y        = y_q;
  assign w11_out  = w11_q;
  assign w12_out  = w12_q;
  assign w21_out  = w21_q;
  assign w22_out  = w22_q;
  assign w31_out  = w31_q;
  assign w32_out  = w32_q;
  assign b1_out   = b1_q;
  assign b2_out   = b2_q;
  assign b3_out   = b3_q;
  assign fp_valid = fp_valid_q;

endmodule

// File: tb/tb_forward_propagation.sv
// Directed bench for forward_propagation: XOR truth-table passes, handshake timing,
// operand latching, mid-pass reset and standalone PLAN sigmoid vectors.
module tb_forward_propagation;

  logic        clk = 1'b0;
  logic        rst, enable_fp;
  logic [15:0] x1, x2, w11, w12, w21, w22, w31, w32, b1, b2, b3;
  logic [15:0] h1, h2, y;
  logic [15:0] w11_out, w12_out, w21_out, w22_out, w31_out, w32_out, b1_out, b2_out, b3_out;
  logic        fp_valid;
  logic [15:0] sig_z, sig_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  forward_propagation #(.dataWidth(16)) dut (
    .clk(clk), .rst(rst), .enable_fp(enable_fp), .x1(x1), .x2(x2),
    .w11(w11), .w12(w12), .w21(w21), .w22(w22), .w31(w31), .w32(w32),
    .b1(b1), .b2(b2), .b3(b3), .h1(h1), .h2(h2), .y(y),
    .w11_out(w11_out), .w12_out(w12_out), .w21_out(w21_out), .w22_out(w22_out),
    .w31_out(w31_out), .w32_out(w32_out), .b1_out(b1_out), .b2_out(b2_out),
    .b3_out(b3_out), .fp_valid(fp_valid)
  );

  forward_propagation_sigmoid_plan u_sig (.z_i(sig_z), .sig_o(sig_s));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the start edge until fp_valid is seen; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (fp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_pass(input logic [15:0] a, input logic [15:0] b, output int lat);
    x1 = a;
    x2 = b;
    enable_fp = 1'b1;
    tick();
    wait_valid(lat);
  endtask

  task automatic release_en();
    enable_fp = 1'b0;
    tick();
  endtask

  task automatic set_weights();
    w11 = 16'h0600; w12 = 16'h0600; w21 = 16'h0600; w22 = 16'h0600;
    b1  = 16'hFC00; b2  = 16'hF900;
    w31 = 16'h0C00; w32 = 16'h0C00; b3 = 16'hFE00;
  endtask

  initial begin
    int lat;
    int hi_cnt;
    rst = 1'b1;
    enable_fp = 1'b0;
    x1 = 16'h1234; x2 = 16'h4321;
    w11 = 16'h1111; w12 = 16'h2222; w21 = 16'h3333; w22 = 16'h4444;
    w31 = 16'h5555; w32 = 16'h6666; b1 = 16'h7777; b2 = 16'h1212; b3 = 16'h3434;
    sig_z = 16'h0000;
    tick(); tick();
    check("rst_h1", h1, 0);
    check("rst_y", y, 0);
    check("rst_w11_out", w11_out, 0);
    check("rst_b3_out", b3_out, 0);
    check("rst_valid", fp_valid, 0);
    rst = 1'b0;
    set_weights();
    tick();

    // x = (0,0)
    do_pass(16'h0000, 16'h0000, lat);
    check("p00_latency", lat, 5);
    check("p00_h1", h1, 16'h0008);
    check("p00_h2", h2, 16'h0000);
    check("p00_y", y, 16'h002C);
    release_en();
    check("p00_valid_fall", fp_valid, 0);
    check("p00_y_hold", y, 16'h002C);

    // x = (0,1.0)
    do_pass(16'h0000, 16'h0100, lat);
    check("p01_latency", lat, 5);
    check("p01_h1", h1, 16'h00E0);
    check("p01_h2", h2, 16'h0040);
    check("p01_y", y, 16'h0100);
    release_en();

    // x = (1.0,0)
    do_pass(16'h0100, 16'h0000, lat);
    check("p10_h1", h1, 16'h00E0);
    check("p10_h2", h2, 16'h0040);
    check("p10_y", y, 16'h0100);
    release_en();

    // x = (1.0,1.0) with hold/release
    do_pass(16'h0100, 16'h0100, lat);
    check("p11_latency", lat, 5);
    check("p11_h1", h1, 16'h0100);
    check("p11_h2", h2, 16'h0100);
    check("p11_y", y, 16'h0100);
    check("p11_w11_out", w11_out, 16'h0600);
    check("p11_w12_out", w12_out, 16'h0600);
    check("p11_w21_out", w21_out, 16'h0600);
    check("p11_w22_out", w22_out, 16'h0600);
    check("p11_w31_out", w31_out, 16'h0C00);
    check("p11_w32_out", w32_out, 16'h0C00);
    check("p11_b1_out", b1_out, 16'hFC00);
    check("p11_b2_out", b2_out, 16'hF900);
    check("p11_b3_out", b3_out, 16'hFE00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", fp_valid, 1);
    end
    release_en();
    check("release_valid", fp_valid, 0);
    tick(); tick();
    check("release_y_hold", y, 16'h0100);
    check("release_h2_hold", h2, 16'h0100);
    check("release_valid_low", fp_valid, 0);

    // inputs change right after being latched
    x1 = 16'h0000; x2 = 16'h0000;
    enable_fp = 1'b1;
    tick();
    x1 = 16'h0100; x2 = 16'h0100;
    wait_valid(lat);
    check("latch_latency", lat, 5);
    check("latch_h1", h1, 16'h0008);
    check("latch_y", y, 16'h002C);
    release_en();

    // early release: exactly one valid cycle
    x1 = 16'h0000; x2 = 16'h0100;
    enable_fp = 1'b1;
    tick();
    enable_fp = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fp_valid) hi_cnt++;
    end
    check("early_valid_cycles", hi_cnt, 1);
    check("early_y", y, 16'h0100);

    // reset mid-pass, then a fresh pass
    x1 = 16'h0100; x2 = 16'h0000;
    enable_fp = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    enable_fp = 1'b0;
    tick();
    check("midrst_h1", h1, 0);
    check("midrst_y", y, 0);
    check("midrst_w31_out", w31_out, 0);
    check("midrst_valid", fp_valid, 0);
    rst = 1'b0;
    tick();
    do_pass(16'h0000, 16'h0000, lat);
    check("post_rst_latency", lat, 5);
    check("post_rst_h1", h1, 16'h0008);
    check("post_rst_y", y, 16'h002C);
    check("post_rst_b2_out", b2_out, 16'hF900);
    release_en();

    // standalone sigmoid vectors
    sig_z = 16'h0000; #1 check("sig_0000", sig_s, 16'h0080);
    sig_z = 16'h0100; #1 check("sig_0100", sig_s, 16'h00C0);
    sig_z = 16'hFF00; #1 check("sig_FF00", sig_s, 16'h0040);
    sig_z = 16'h0500; #1 check("sig_0500", sig_s, 16'h0100);
    sig_z = 16'h8000; #1 check("sig_8000", sig_s, 16'h0000);
    sig_z = 16'h04FF; #1 check("sig_04FF", sig_s, 16'h00FF);
    sig_z = 16'h0260; #1 check("sig_0260", sig_s, 16'h00EB);
    sig_z = 16'h025F; #1 check("sig_025F", sig_s, 16'h00EB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
